stream_downsize: RTL and testbench

- Width converter from one wide stream beat to several narrow beats; the inverse of stream_upsize.
- Accepts one wide word of T_DATA_RATIO lanes with a per-lane keep mask and a last flag.
- Emits only the kept lanes, lowest index first, as narrow beats. m_last_o is set on the final kept lane of a last word.
- Sits on the wide-to-narrow side of datapaths that use stream_upsize on the way in.

---
 rtl/stream_pkg.sv | 19 +
 rtl/lsb_prio_enc.sv | 24 ++
 rtl/stream_downsize.sv | 84 ++++++++
 tb/tb_stream_downsize.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// Shared helpers for the stream width converters: lane index sizing and
// a single-bit-set test used to spot the final lane of a word.
package stream_pkg;

    localparam int unsigned MaxLanes = 64;
    localparam int unsigned MaxIdxW  = 6;

    typedef logic [MaxIdxW-1:0] lane_idx_t;

    function automatic int unsigned lane_idx_w(input int unsigned ratio);
        return $clog2(ratio);
    endfunction

    // Callers zero-extend their mask to MaxLanes bits.
    function automatic logic onehot_last(input logic [MaxLanes-1:0] mask);
        return $countones(mask) == 1;
    endfunction

endpackage

// File: rtl/lsb_prio_enc.sv
// Priority encoder: index of the lowest set bit of mask, plus an any-set flag.
module lsb_prio_enc
    import stream_pkg::*;
#(
    parameter int unsigned N = 2,
    parameter int unsigned W = lane_idx_w(N)
) (
    input  logic [N-1:0] mask,
    output logic [W-1:0] idx,
    output logic         any
);

    always_comb begin
        idx = '0;
        any = |mask;
        // Walk downward so the lowest set bit is the last one written.
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = W'(i);
            end
        end
    end

endmodule

// File: rtl/stream_downsize.sv
// Wide-to-narrow stream converter: emits the kept lanes of each word, lowest first.
// Define STREAM_DOWNSIZE_BYPASS_EN to let a new word load as the final beat leaves.
module stream_downsize
    import stream_pkg::*;
#(
    parameter int unsigned T_DATA_WIDTH = 4,
    parameter int unsigned T_DATA_RATIO = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [T_DATA_WIDTH-1:0] s_data_i [T_DATA_RATIO-1:0],
    input  logic [T_DATA_RATIO-1:0] s_keep_i,
    input  logic                    s_last_i,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    output logic [T_DATA_WIDTH-1:0] m_data_o,
    output logic                    m_last_o,
    output logic                    m_valid_o,
    input  logic                    m_ready_i
);

    localparam int unsigned IdxW = lane_idx_w(T_DATA_RATIO);

    logic [T_DATA_WIDTH-1:0] data_q [T_DATA_RATIO-1:0];
    logic [T_DATA_RATIO-1:0] rem_q;
    logic [T_DATA_RATIO-1:0] rem_d;
    logic                    last_q;
    logic [IdxW-1:0]         sel;
    logic                    busy;
    logic                    one_left;
    logic                    load;
    logic                    take;

    lsb_prio_enc #(
        .N (T_DATA_RATIO),
        .W (IdxW)
    ) u_enc (
        .mask (rem_q),
        .idx  (sel),
        .any  (busy)
    );

    assign one_left  = onehot_last(MaxLanes'(rem_q));
    assign m_valid_o = busy;
    assign m_data_o  = data_q[sel];
    assign m_last_o  = last_q & one_left;

`ifdef STREAM_DOWNSIZE_BYPASS_EN
    assign s_ready_o = ~busy | (m_ready_i & one_left);
`else
    assign s_ready_o = ~busy;
`endif

    assign load = s_valid_i & s_ready_o;
    assign take = m_valid_o & m_ready_i;

    // A load overrides the clear of the outgoing final lane.
    always_comb begin
        rem_d = rem_q;
        if (take) begin
            rem_d[sel] = 1'b0;
        end
        if (load) begin
            rem_d = s_keep_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q  <= '0;
            last_q <= 1'b0;
            for (int i = 0; i < int'(T_DATA_RATIO); i++) begin
                data_q[i] <= '0;
            end
        end else begin
            rem_q <= rem_d;
            if (load) begin
                data_q <= s_data_i;
                last_q <= s_last_i;
            end
        end
    end

endmodule

// File: tb/tb_stream_downsize.sv
// Scoreboard bench for stream_downsize (RATIO=4, WIDTH=4); kept lanes are queued on accept.
module tb_stream_downsize;

    localparam int unsigned W  = 4;
    localparam int unsigned R  = 4;
    localparam int unsigned DW = R * W;

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] s_data_i [R-1:0];
    logic [R-1:0] s_keep_i;
    logic         s_last_i;
    logic         s_valid_i;
    logic         s_ready_o;
    logic [W-1:0] m_data_o;
    logic         m_last_o;
    logic         m_valid_o;
    logic         m_ready_i;

    beat_t exp_q[$];
    int    vectors     = 0;
    int    miscompares = 0;
    bit    prod_done;

    stream_downsize #(
        .T_DATA_WIDTH (W),
        .T_DATA_RATIO (R)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_data_i  (s_data_i),
        .s_keep_i  (s_keep_i),
        .s_last_i  (s_last_i),
        .s_valid_i (s_valid_i),
        .s_ready_o (s_ready_o),
        .m_data_o  (m_data_o),
        .m_last_o  (m_last_o),
        .m_valid_o (m_valid_o),
        .m_ready_i (m_ready_i)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    // Drives one word, waits for acceptance, queues the expected narrow beats.
    task automatic send_word(input logic [DW-1:0] data, input logic [R-1:0] keep,
                             input logic last);
        int tmo = 0;
        @(negedge clk);
        for (int i = 0; i < int'(R); i++) s_data_i[i] = data[i*W +: W];
        s_keep_i  = keep;
        s_last_i  = last;
        s_valid_i = 1'b1;
        #1;
        while (!s_ready_o && tmo < 200) begin
            @(negedge clk);
            #1;
            tmo++;
        end
        if (!s_ready_o) begin
            miscompares++;
            $display("FAIL send_word: s_ready_o=%b after 200 cycles, required 1", s_ready_o);
        end else begin
            for (int i = 0; i < int'(R); i++) begin
                if (keep[i]) begin
                    beat_t b;
                    b.data = data[i*W +: W];
                    b.last = last && ((keep >> (i + 1)) == '0);
                    exp_q.push_back(b);
                end
            end
        end
        @(posedge clk);
        #1;
        s_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        s_valid_i = 1'b0;
        m_ready_i = 1'b0;
        s_keep_i  = '0;
        s_last_i  = 1'b0;
        for (int i = 0; i < int'(R); i++) s_data_i[i] = '0;
        #12;
        vectors++;
        if ({m_valid_o, m_last_o, m_data_o} !== {1'b0, 1'b0, W'(0)}) begin
            miscompares++;
            $display("FAIL reset_outputs: valid/last/data=%b/%b/%h, required 0/0/0",
                     m_valid_o, m_last_o, m_data_o);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if (s_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: s_ready_o=%b, required 1", s_ready_o);
        end
    endtask

    task automatic test_full_word();
        beat_t b;
        logic  exp_rdy;
        m_ready_i = 1'b1;
        send_word({4'hD, 4'hC, 4'hB, 4'hA}, 4'b1111, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            b = '0;
            if (exp_q.size() != 0) b = exp_q.pop_front();
`ifdef STREAM_DOWNSIZE_BYPASS_EN
            exp_rdy = (i == 3);
`else
            exp_rdy = 1'b0;
`endif
            vectors++;
            if ({m_valid_o, m_data_o, m_last_o, s_ready_o} !== {1'b1, b.data, b.last, exp_rdy}) begin
                miscompares++;
                $display("FAIL full_word beat %0d: v/d/l/rdy=%b/%h/%b/%b, required 1/%h/%b/%b",
                         i, m_valid_o, m_data_o, m_last_o, s_ready_o, b.data, b.last, exp_rdy);
            end
        end
        @(negedge clk);
        #1;
        vectors++;
        if ({m_valid_o, s_ready_o} !== 2'b01) begin
            miscompares++;
            $display("FAIL full_word idle: valid/ready=%b/%b, required 0/1", m_valid_o, s_ready_o);
        end
    endtask

    task automatic test_sparse_keep();
        beat_t b;
        int    cyc   = 0;
        int    beats = 0;
        m_ready_i = 1'b1;
        send_word({4'h4, 4'h3, 4'h2, 4'h1}, 4'b1010, 1'b1);
        while (cyc < 6) begin
            @(negedge clk);
            #1;
            cyc++;
            if (m_valid_o) begin
                beats++;
                b = '0;
                if (exp_q.size() != 0) b = exp_q.pop_front();
                vectors++;
                if ({m_data_o, m_last_o} !== {b.data, b.last}) begin
                    miscompares++;
                    $display("FAIL sparse_keep beat: data/last=%h/%b, required %h/%b",
                             m_data_o, m_last_o, b.data, b.last);
                end
            end
        end
        vectors++;
        if (beats != 2) begin
            miscompares++;
            $display("FAIL sparse_keep count: %0d beats, required 2", beats);
        end
        exp_q.delete();
    endtask

    task automatic test_zero_keep();
        beat_t b;
        int    cyc = 0;
        m_ready_i = 1'b1;
        send_word({4'hF, 4'hE, 4'hD, 4'hC}, 4'b0000, 1'b0);
        @(negedge clk);
        #1;
        vectors++;
        if ({m_valid_o, s_ready_o} !== 2'b01) begin
            miscompares++;
            $display("FAIL zero_keep idle: valid/ready=%b/%b, required 0/1", m_valid_o, s_ready_o);
        end
        send_word({4'h0, 4'h0, 4'h0, 4'h5}, 4'b0001, 1'b1);
        while (exp_q.size() != 0 && cyc < 20) begin
            @(negedge clk);
            #1;
            cyc++;
            if (m_valid_o) begin
                b = exp_q.pop_front();
                vectors++;
                if ({m_data_o, m_last_o} !== {4'h5, 1'b1} || {m_data_o, m_last_o} !== {b.data, b.last}) begin
                    miscompares++;
                    $display("FAIL zero_keep single: data/last=%h/%b, required 5/1",
                             m_data_o, m_last_o);
                end
            end
        end
        @(negedge clk);
        #1;
        vectors++;
        if (m_valid_o !== 1'b0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL zero_keep tail: valid=%b pending=%0d, required 0/0",
                     m_valid_o, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        beat_t b;
        int    cyc = 0;
        m_ready_i = 1'b1;
        send_word({4'h8, 4'h7, 4'h6, 4'h5}, 4'b1111, 1'b0);
        @(negedge clk);
        #1;
        b = exp_q.pop_front();
        vectors++;
        if ({m_valid_o, m_data_o, m_last_o} !== {1'b1, b.data, b.last}) begin
            miscompares++;
            $display("FAIL backpressure first: v/d/l=%b/%h/%b, required 1/%h/%b",
                     m_valid_o, m_data_o, m_last_o, b.data, b.last);
        end
        repeat (5) begin
            @(negedge clk);
            m_ready_i = 1'b0;
            #1;
            b = exp_q[0];
            vectors++;
            if ({m_valid_o, m_data_o, m_last_o} !== {1'b1, b.data, b.last}) begin
                miscompares++;
                $display("FAIL backpressure hold: v/d/l=%b/%h/%b, required 1/%h/%b",
                         m_valid_o, m_data_o, m_last_o, b.data, b.last);
            end
        end
        while (exp_q.size() != 0 && cyc < 20) begin
            @(negedge clk);
            m_ready_i = 1'b1;
            #1;
            cyc++;
            if (m_valid_o) begin
                b = exp_q.pop_front();
                vectors++;
                if ({m_data_o, m_last_o} !== {b.data, b.last}) begin
                    miscompares++;
                    $display("FAIL backpressure resume: data/last=%h/%b, required %h/%b",
                             m_data_o, m_last_o, b.data, b.last);
                end
            end
        end
        @(negedge clk);
        #1;
        vectors++;
        if (m_valid_o !== 1'b0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL backpressure tail: valid=%b pending=%0d, required 0/0",
                     m_valid_o, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        int exp_span;
`ifdef STREAM_DOWNSIZE_BYPASS_EN
        exp_span = 12;
`else
        exp_span = 14;
`endif
        m_ready_i = 1'b1;
        prod_done = 1'b0;
        fork
            begin
                for (int w = 0; w < 3; w++) begin
                    send_word(DW'($urandom), 4'b1111, 1'b1);
                end
                prod_done = 1'b1;
            end
            begin
                beat_t b;
                int    cyc   = 0;
                int    first = -1;
                int    lastc = -1;
                while (!(prod_done && exp_q.size() == 0) && cyc < 200) begin
                    @(negedge clk);
                    #1;
                    cyc++;
                    if (m_valid_o && exp_q.size() != 0) begin
                        b = exp_q.pop_front();
                        if (first < 0) first = cyc;
                        lastc = cyc;
                        vectors++;
                        if ({m_data_o, m_last_o} !== {b.data, b.last}) begin
                            miscompares++;
                            $display("FAIL back_to_back beat: data/last=%h/%b, required %h/%b",
                                     m_data_o, m_last_o, b.data, b.last);
                        end
                    end
                end
                vectors++;
                if (lastc - first + 1 != exp_span) begin
                    miscompares++;
                    $display("FAIL back_to_back span: %0d cycles for 12 beats, required %0d",
                             lastc - first + 1, exp_span);
                end
            end
        join
        exp_q.delete();
    endtask

    task automatic test_random();
        prod_done = 1'b0;
        fork
            begin
                for (int w = 0; w < 30; w++) begin
                    logic [DW-1:0] d;
                    logic [R-1:0]  k;
                    logic          l;
                    d = DW'($urandom);
                    k = R'($urandom_range(1, 15));
                    l = 1'($urandom_range(0, 1));
                    repeat ($urandom_range(0, 10)) @(negedge clk);
                    send_word(d, k, l);
                end
                prod_done = 1'b1;
            end
            begin
                beat_t b;
                beat_t pb;
                logic  pv    = 1'b0;
                logic  pr    = 1'b1;
                int    cyc   = 0;
                int    stall = 0;
                pb = '0;
                while (!(prod_done && exp_q.size() == 0) && cyc < 5000) begin
                    @(negedge clk);
                    if (stall > 0) begin
                        m_ready_i = 1'b0;
                        stall--;
                    end else begin
                        m_ready_i = 1'b1;
                        if ($urandom_range(0, 3) == 0) stall = $urandom_range(0, 10);
                    end
                    #1;
                    cyc++;
                    if (pv && !pr) begin
                        vectors++;
                        if ({m_valid_o, m_data_o, m_last_o} !== {1'b1, pb.data, pb.last}) begin
                            miscompares++;
                            $display("FAIL random hold: v/d/l=%b/%h/%b, required 1/%h/%b",
                                     m_valid_o, m_data_o, m_last_o, pb.data, pb.last);
                        end
                    end
                    pv = m_valid_o;
                    pr = m_ready_i;
                    pb.data = m_data_o;
                    pb.last = m_last_o;
                    if (m_valid_o && m_ready_i) begin
                        b = '0;
                        if (exp_q.size() != 0) b = exp_q.pop_front();
                        vectors++;
                        if ({m_data_o, m_last_o} !== {b.data, b.last}) begin
                            miscompares++;
                            $display("FAIL random beat: data/last=%h/%b, required %h/%b",
                                     m_data_o, m_last_o, b.data, b.last);
                        end
                    end
                end
            end
        join
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL random drain: %0d beats outstanding, required 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_mid_reset();
        beat_t b;
        int    cyc = 0;
        m_ready_i = 1'b1;
        send_word({4'h9, 4'h8, 4'h7, 4'h6}, 4'b1111, 1'b1);
        @(negedge clk);
        #1;
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if ({m_valid_o, m_last_o} !== 2'b00) begin
            miscompares++;
            $display("FAIL mid_reset async: valid/last=%b/%b, required 0/0", m_valid_o, m_last_o);
        end
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            vectors++;
            if ({m_valid_o, s_ready_o} !== 2'b01) begin
                miscompares++;
                $display("FAIL mid_reset quiet: valid/ready=%b/%b, required 0/1",
                         m_valid_o, s_ready_o);
            end
        end
        send_word({4'h4, 4'h3, 4'h2, 4'h1}, 4'b1111, 1'b1);
        while (exp_q.size() != 0 && cyc < 20) begin
            @(negedge clk);
            #1;
            cyc++;
            if (m_valid_o) begin
                b = exp_q.pop_front();
                vectors++;
                if ({m_data_o, m_last_o} !== {b.data, b.last}) begin
                    miscompares++;
                    $display("FAIL mid_reset next word: data/last=%h/%b, required %h/%b",
                             m_data_o, m_last_o, b.data, b.last);
                end
            end
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL mid_reset drain: %0d beats outstanding, required 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_sparse_keep();
        test_zero_keep();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
